kugelblitz_patch_engine: RTL and testbench



---
 rtl/kugelblitz_pkg.sv | 25 ++
 rtl/kugelblitz_patch_lane.sv | 32 +++
 rtl/kugelblitz_patch_engine.sv | 194 +++++++++++++++++++
 tb/tb_kugelblitz_patch_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kugelblitz_pkg.sv
// Shared cfg address map, rule field layout and types for the kugelblitz patch engine.
package kugelblitz_pkg;
  localparam logic [7:0] RULE_BASE   = 8'h00;
  localparam logic [7:0] CTRL_ADDR   = 8'h40;
  localparam logic [7:0] STAT_FRAMES = 8'h80;
  localparam logic [7:0] STAT_BYTES  = 8'h81;

  localparam int RULE_EN_BIT  = 31;
  localparam int RULE_OFF_LSB = 8;
  localparam int RULE_DAT_LSB = 0;
  localparam int RULE_DAT_W   = 8;
  localparam int MAX_OFF_W    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_t;

  // Offset is held at full width; bits above OFFSET_WIDTH are always zero.
  typedef struct packed {
    logic                  en;
    logic [MAX_OFF_W-1:0]  off;
    logic [RULE_DAT_W-1:0] dat;
  } rule_t;
endpackage

// File: rtl/kugelblitz_patch_lane.sv
// One byte lane: matches the lane's absolute frame offset against every rule, lowest index wins.
// Purely combinational; dropped (tkeep=0) lanes are forced to zero and never count as patched.
module kugelblitz_patch_lane
  import kugelblitz_pkg::*;
#(
  parameter int NUM_RULES = 4,
  parameter int LANE      = 0
) (
  input  logic [31:0]                 i_base,
  input  rule_t [NUM_RULES-1:0]       i_rules,
  input  logic                        i_gen,
  input  logic                        i_keep,
  input  logic [RULE_DAT_W-1:0]       i_byte,
  output logic [RULE_DAT_W-1:0]       o_byte,
  output logic                        o_hit
);
  logic [31:0] w_offset;

  assign w_offset = i_base + 32'(LANE);

  always_comb begin
    o_hit  = 1'b0;
    o_byte = i_keep ? i_byte : '0;
    // Walk from the top so the lowest-numbered matching rule is the last writer.
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (i_gen && i_keep && i_rules[i].en && (32'(i_rules[i].off) == w_offset)) begin
        o_hit  = 1'b1;
        o_byte = i_rules[i].dat;
      end
    end
  end
endmodule

// File: rtl/kugelblitz_patch_engine.sv
// AXI-stream byte patcher: one register stage (latency 1), tready = !m_tvalid || m_tready, full rate.
// Optional frame/patched-byte counters at 0x80/0x81 when KG_PATCH_STATS_EN is defined.
module kugelblitz_patch_engine
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int NUM_RULES    = 4,
  parameter int OFFSET_WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  input  logic                   cfg_wr_en,
  input  logic                   cfg_rd_en,
  input  logic [7:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  output logic                   cfg_rd_valid
);
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_keep_chk
    $error("KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (NUM_RULES < 1 || NUM_RULES > 16 || OFFSET_WIDTH > MAX_OFF_W) begin : g_range_chk
    $error("NUM_RULES must be 1..16 and OFFSET_WIDTH <= 16");
  end

  frame_state_t              r_state, w_state_nxt;
  logic                      w_first;
  logic [OFFSET_WIDTH-1:0]   r_beat;
  rule_t [NUM_RULES-1:0]     r_rules, r_snap, w_rules;
  logic                      r_gen, r_snap_gen, w_gen;
  logic [31:0]               w_base;
  logic [DATA_WIDTH-1:0]     w_pdata;
  logic [KEEP_WIDTH-1:0]     w_hits;
  logic                      w_acc, w_out_hs;
  logic                      r_tvalid, r_tlast;
  logic [DATA_WIDTH-1:0]     r_tdata;
  logic [KEEP_WIDTH-1:0]     r_tkeep;
  logic [USER_WIDTH-1:0]     r_tuser;
  logic [31:0]               r_rdata, w_rd_dat;
  logic                      r_rd_vld;
  logic                      w_unused;

  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_out_hs      = r_tvalid && m_axis_tready;
  assign s_axis_tready = !r_tvalid || m_axis_tready;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign cfg_rdata     = r_rdata;
  assign cfg_rd_valid  = r_rd_vld;
  assign w_unused      = ^{cfg_wdata, w_hits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = (r_state == ST_IDLE);
    if (w_acc) w_state_nxt = s_axis_tlast ? ST_IDLE : ST_FRAME;
  end

  // The first beat sees the live registers, which are exactly what the snapshot captures.
  assign w_rules = w_first ? r_rules : r_snap;
  assign w_gen   = w_first ? r_gen : r_snap_gen;
  assign w_base  = 32'(r_beat) * 32'(KEEP_WIDTH);

  for (genvar l = 0; l < KEEP_WIDTH; l++) begin : g_lane
    kugelblitz_patch_lane #(.NUM_RULES(NUM_RULES), .LANE(l)) u_lane (
      .i_base  (w_base),
      .i_rules (w_rules),
      .i_gen   (w_gen),
      .i_keep  (s_axis_tkeep[l]),
      .i_byte  (s_axis_tdata[8*l +: 8]),
      .o_byte  (w_pdata[8*l +: 8]),
      .o_hit   (w_hits[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= '0;
    end else if (w_acc) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_pdata;
      r_tkeep  <= s_axis_tkeep;
      r_tlast  <= s_axis_tlast;
      r_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_snap     <= '0;
      r_snap_gen <= 1'b1;
    end else if (w_acc) begin
      if (w_first) begin
        r_snap     <= r_rules;
        r_snap_gen <= r_gen;
      end
      if (s_axis_tlast)     r_beat <= '0;
      else if (r_beat != '1) r_beat <= r_beat + OFFSET_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rules <= '0;
      r_gen   <= 1'b1;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_addr == RULE_BASE + 8'(i)) begin
          r_rules[i].en  <= cfg_wdata[RULE_EN_BIT];
          r_rules[i].off <= MAX_OFF_W'(cfg_wdata[RULE_OFF_LSB +: OFFSET_WIDTH]);
          r_rules[i].dat <= cfg_wdata[RULE_DAT_LSB +: RULE_DAT_W];
        end
      end
      if (cfg_addr == CTRL_ADDR) r_gen <= cfg_wdata[0];
    end
  end

`ifdef KG_PATCH_STATS_EN
  logic [KEEP_WIDTH-1:0] r_hits;
  logic [31:0]           r_frames, r_pbytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_hits <= '0;
    else if (w_acc) r_hits <= w_hits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames <= '0;
      r_pbytes <= '0;
    end else if (cfg_wr_en && (cfg_addr == STAT_FRAMES || cfg_addr == STAT_BYTES)) begin
      r_frames <= '0;
      r_pbytes <= '0;
    end else if (w_out_hs) begin
      if (r_tlast) r_frames <= r_frames + 32'd1;
      r_pbytes <= r_pbytes + 32'($countones(r_hits));
    end
  end
`endif

  always_comb begin
    w_rd_dat = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (cfg_addr == RULE_BASE + 8'(i)) begin
        w_rd_dat[RULE_EN_BIT]                    = r_rules[i].en;
        w_rd_dat[RULE_OFF_LSB +: OFFSET_WIDTH]   = r_rules[i].off[OFFSET_WIDTH-1:0];
        w_rd_dat[RULE_DAT_LSB +: RULE_DAT_W]     = r_rules[i].dat;
      end
    end
    if (cfg_addr == CTRL_ADDR) w_rd_dat[0] = r_gen;
`ifdef KG_PATCH_STATS_EN
    if (cfg_addr == STAT_FRAMES) w_rd_dat = r_frames;
    if (cfg_addr == STAT_BYTES)  w_rd_dat = r_pbytes;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rd_vld <= cfg_rd_en;
      if (cfg_rd_en) r_rdata <= w_rd_dat;
    end
  end
endmodule

// File: tb/tb_kugelblitz_patch_engine.sv
// Directed bench for kugelblitz_patch_engine (512-bit data, 4 rules); checks with immediate assertions.
module tb_kugelblitz_patch_engine;
  localparam int DW = 512;
  localparam int KW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic [KW-1:0]   s_axis_tkeep = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [0:0]      s_axis_tuser = '0;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic [0:0]      m_axis_tuser;
  logic            cfg_wr_en = 1'b0;
  logic            cfg_rd_en = 1'b0;
  logic [7:0]      cfg_addr = '0;
  logic [31:0]     cfg_wdata = '0;
  logic [31:0]     cfg_rdata;
  logic            cfg_rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q_din[$];
  logic [DW-1:0] q_dexp[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];
  logic          q_user[$];

  always #5 clk = ~clk;

  kugelblitz_patch_engine dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] seed);
    logic [DW-1:0] v;
    for (int l = 0; l < KW; l++) v[8*l +: 8] = seed + 8'(l);
    return v;
  endfunction

  function automatic logic [DW-1:0] set_byte(input logic [DW-1:0] v, input int idx, input logic [7:0] b);
    v[8*idx +: 8] = b;
    return v;
  endfunction

  function automatic logic [DW-1:0] mask(input logic [DW-1:0] v, input logic [KW-1:0] k);
    for (int l = 0; l < KW; l++) if (!k[l]) v[8*l +: 8] = 8'h00;
    return v;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                      input logic u, input logic [DW-1:0] e);
    q_din.push_back(d); q_keep.push_back(k); q_last.push_back(l);
    q_user.push_back(u); q_dexp.push_back(e);
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cfg_rd_en = 1'b1; cfg_addr = a;
    @(posedge clk); #1;
    cfg_rd_en = 1'b0;
    chk({tag, "_vld"}, 576'(cfg_rd_valid), 576'(1));
    chk(tag, 576'(cfg_rdata), 576'(exp));
  endtask

  // Streams the queued beats, optionally with random output stalls and a rule0 write at a given beat.
  task automatic run(input bit rnd, input int wr_beat, input logic [31:0] wr_d);
    int si, mi, cyc, nb;
    logic held_v;
    logic [DW-1:0] held_d;
    si = 0; mi = 0; cyc = 0; held_v = 1'b0; held_d = '0; nb = q_din.size();
    while ((si < nb || mi < nb) && cyc < 4000) begin
      if (si < nb) begin
        s_axis_tvalid = 1'b1; s_axis_tdata = q_din[si]; s_axis_tkeep = q_keep[si];
        s_axis_tlast = q_last[si]; s_axis_tuser = q_user[si];
      end else begin
        s_axis_tvalid = 1'b0;
      end
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_wr_en = (si == wr_beat); cfg_addr = 8'h00; cfg_wdata = wr_d;
      #1;
      if (held_v) begin
        chk("stall_vld", 576'(m_axis_tvalid), 576'(1));
        chk("stall_dat", 576'(m_axis_tdata), 576'(held_d));
      end
      held_v = m_axis_tvalid && !m_axis_tready;
      held_d = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        if (mi < nb) begin
          chk("beat_dat", 576'(m_axis_tdata), 576'(q_dexp[mi]));
          chk("beat_side", 576'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
              576'({q_keep[mi], q_last[mi], q_user[mi]}));
          mi++;
        end else begin
          n_cmp++; n_bad++;
          $error("FAIL extra_beat observed=%0d expected=%0d", mi + 1, nb);
        end
      end
      if (s_axis_tvalid && s_axis_tready) si++;
      @(posedge clk); #1;
      cyc++;
    end
    s_axis_tvalid = 1'b0; cfg_wr_en = 1'b0; m_axis_tready = 1'b1;
    if (si < nb || mi < nb) begin
      n_cmp++; n_bad++;
      $error("FAIL run_timeout observed=%0d/%0d expected=%0d", si, mi, nb);
    end else begin
      chk("drained", 576'(m_axis_tvalid), 576'(0));
    end
    q_din.delete(); q_dexp.delete(); q_keep.delete(); q_last.delete(); q_user.delete();
  endtask

  initial begin
    logic [DW-1:0] d, e;
    logic [KW-1:0] k;
    int nbeats, n_patched;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvld", 576'(m_axis_tvalid), 576'(0));
    chk("rst_mdat", 576'(m_axis_tdata), 576'(0));
    chk("rst_mside", 576'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 576'(0));
    chk("rst_rd", 576'({cfg_rd_valid, cfg_rdata}), 576'(0));
    rst_n = 1'b1;
    chk("rst_srdy", 576'(s_axis_tready), 576'(1));
    @(posedge clk); #1;
    cfg_rd("ctrl_rst", 8'h40, 32'h1);
    cfg_rd("rule0_rst", 8'h00, 32'h0);
    cfg_wr(8'h20, 32'hDEAD_BEEF);
    cfg_rd("unmapped", 8'h20, 32'h0);
    cfg_rd("stat_rst", 8'h80, 32'h0);

    // Single-beat frame, latency 1
    cfg_wr(8'h00, 32'h8000_05AA);
    cfg_rd("rule0_rb", 8'h00, 32'h8000_05AA);
    d = {64{8'h11}};
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = '1; s_axis_tlast = 1'b1; s_axis_tuser = 1'b1;
    #1;
    chk("lat_srdy", 576'(s_axis_tready), 576'(1));
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    chk("lat_vld", 576'(m_axis_tvalid), 576'(1));
    chk("lat_dat", 576'(m_axis_tdata), 576'(set_byte(d, 5, 8'hAA)));
    chk("lat_side", 576'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 576'({{KW{1'b1}}, 2'b11}));
    @(posedge clk); #1;
    chk("lat_done", 576'(m_axis_tvalid), 576'(0));

    // Offset 70 lands in beat 1 lane 6
    cfg_wr(8'h00, 32'h0000_05AA);
    cfg_wr(8'h01, 32'h8000_4655);
    push(fill(8'h20), '1, 1'b0, 1'b0, fill(8'h20));
    push(fill(8'h40), '1, 1'b0, 1'b1, set_byte(fill(8'h40), 6, 8'h55));
    push(fill(8'h60), '1, 1'b1, 1'b0, fill(8'h60));
    run(1'b0, -1, 32'h0);

    // Priority: rule0 beats rule2 on the same byte, rule2 wins once rule0 is off
    cfg_wr(8'h01, 32'h0);
    cfg_wr(8'h00, 32'h8000_0301);
    cfg_wr(8'h02, 32'h8000_0302);
    push(fill(8'h70), '1, 1'b1, 1'b0, set_byte(fill(8'h70), 3, 8'h01));
    run(1'b0, -1, 32'h0);
    cfg_wr(8'h00, 32'h0);
    push(fill(8'h70), '1, 1'b1, 1'b0, set_byte(fill(8'h70), 3, 8'h02));
    run(1'b0, -1, 32'h0);

    // tkeep: dropped lanes read zero and are never patched
    k = 64'hFFFF_FFFF_FFFF_FF05;
    push(fill(8'h80), k, 1'b1, 1'b0, mask(fill(8'h80), k));
    k = 64'h0000_0000_0000_000F;
    push(fill(8'h80), k, 1'b1, 1'b1, set_byte(mask(fill(8'h80), k), 3, 8'h02));
    run(1'b0, -1, 32'h0);

    // Global enable off
    cfg_wr(8'h40, 32'h0);
    cfg_rd("ctrl_off", 8'h40, 32'h0);
    push(fill(8'h90), '1, 1'b1, 1'b0, fill(8'h90));
    run(1'b0, -1, 32'h0);
    cfg_wr(8'h40, 32'h1);

    // Offset 200 (beat 3 lane 8): no effect on a short frame, counter restarts for the next
    cfg_wr(8'h02, 32'h8000_C8EE);
    push(fill(8'hA0), '1, 1'b0, 1'b0, fill(8'hA0));
    push(fill(8'hB0), '1, 1'b1, 1'b0, fill(8'hB0));
    push(fill(8'h00), '1, 1'b0, 1'b0, fill(8'h00));
    push(fill(8'h10), '1, 1'b0, 1'b0, fill(8'h10));
    push(fill(8'h20), '1, 1'b0, 1'b0, fill(8'h20));
    push(fill(8'h30), '1, 1'b1, 1'b1, set_byte(fill(8'h30), 8, 8'hEE));
    run(1'b0, -1, 32'h0);
    cfg_wr(8'h02, 32'h0);

    // Snapshot: mid-frame write and same-cycle-as-first-beat write both deferred
    cfg_wr(8'h00, 32'h8000_05AA);
    push(fill(8'h01), '1, 1'b0, 1'b0, set_byte(fill(8'h01), 5, 8'hAA));
    push(fill(8'h02), '1, 1'b0, 1'b0, fill(8'h02));
    push(fill(8'h03), '1, 1'b0, 1'b0, fill(8'h03));
    push(fill(8'h04), '1, 1'b1, 1'b0, fill(8'h04));
    run(1'b0, 1, 32'h8000_05BB);
    push(fill(8'h05), '1, 1'b1, 1'b0, set_byte(fill(8'h05), 5, 8'hBB));
    run(1'b0, 0, 32'h8000_05CC);
    push(fill(8'h06), '1, 1'b1, 1'b0, set_byte(fill(8'h06), 5, 8'hCC));
    run(1'b0, -1, 32'h0);
    cfg_rd("rule0_cc", 8'h00, 32'h8000_05CC);

    // 100 frames with random output stalls
    cfg_wr(8'h00, 32'h8000_05AA);
    cfg_wr(8'h80, 32'h0);
    n_patched = 0;
    for (int f = 0; f < 100; f++) begin
      nbeats = 1 + f % 3;
      for (int b = 0; b < nbeats; b++) begin
        d = fill(8'(f * 5 + b * 17));
        k = (nbeats == 1 && f % 4 == 3) ? 64'hFFFF_FFFF_FFFF_FFDF : '1;
        e = mask(d, k);
        if (b == 0 && k[5]) begin
          e = set_byte(e, 5, 8'hAA);
          n_patched++;
        end
        push(d, k, 1'(b == nbeats - 1), 1'(b), e);
      end
    end
    run(1'b1, -1, 32'h0);
`ifdef KG_PATCH_STATS_EN
    cfg_rd("stat_frames", 8'h80, 32'd100);
    cfg_rd("stat_bytes", 8'h81, 32'(n_patched));
    cfg_wr(8'h81, 32'h0);
    cfg_rd("stat_clr", 8'h80, 32'h0);
`else
    cfg_rd("stat_frames_off", 8'h80, 32'h0);
    cfg_wr(8'h81, 32'hFFFF_FFFF);
    cfg_rd("stat_bytes_off", 8'h81, 32'h0);
`endif

    // Reset in the middle of a 4-beat frame
    s_axis_tvalid = 1'b1; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    s_axis_tdata = fill(8'h70);
    @(posedge clk); #1;
    s_axis_tdata = fill(8'h71);
    @(posedge clk); #1;
    s_axis_tdata = fill(8'h72);
    chk("mid_vld", 576'(m_axis_tvalid), 576'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 576'(m_axis_tvalid), 576'(0));
    chk("mid_rst_dat", 576'(m_axis_tdata), 576'(0));
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_srdy", 576'(s_axis_tready), 576'(1));
    cfg_rd("mid_ctrl", 8'h40, 32'h1);
    cfg_rd("mid_rule0", 8'h00, 32'h0);
    cfg_wr(8'h00, 32'h8000_05AA);
    push(fill(8'h50), '1, 1'b0, 1'b0, set_byte(fill(8'h50), 5, 8'hAA));
    push(fill(8'h60), '1, 1'b1, 1'b1, fill(8'h60));
    run(1'b0, -1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
